// File: rtl/ysyx_22050039_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
package ysyx_22050039_pkg;

    localparam int unsigned XLEN_DEFAULT     = 64;
    localparam int unsigned FUNC_W           = 3;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // Sequencer states; HALT and TRAP are terminal until reset.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_TRAP  = 3'd6
    } seq_state_e;

    // Execute function codes produced by decode.
    localparam logic [FUNC_W-1:0] FUNC_ADD    = 3'd0;
    localparam logic [FUNC_W-1:0] FUNC_JALR   = 3'd1;
    localparam logic [FUNC_W-1:0] FUNC_AUIPC  = 3'd2;
    localparam logic [FUNC_W-1:0] FUNC_LUI    = 3'd3;
    localparam logic [FUNC_W-1:0] FUNC_STORE  = 3'd4;
    localparam logic [FUNC_W-1:0] FUNC_JAL    = 3'd5;
    localparam logic [FUNC_W-1:0] FUNC_EBREAK = 3'd6;
    localparam logic [FUNC_W-1:0] FUNC_INV    = 3'd7;

    // Function codes that write a destination register at writeback.
    function automatic logic func_writes_rf(input logic [FUNC_W-1:0] func);
        return (func == FUNC_ADD)   || (func == FUNC_JALR) ||
               (func == FUNC_AUIPC) || (func == FUNC_LUI)  ||
               (func == FUNC_JAL);
    endfunction

    // Function codes whose next PC comes from the execute unit.
    function automatic logic func_is_jump(input logic [FUNC_W-1:0] func);
        return (func == FUNC_JALR) || (func == FUNC_JAL);
    endfunction

endpackage

// File: rtl/ysyx_22050039_perf_cnt.sv
// Active-cycle and retired-instruction counters (64-bit, wrapping).
module ysyx_22050039_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_inc_i,
    input  logic        ret_inc_i,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_cnt_o
);

    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    // Count on the increment strobes; natural wrap at 2^64.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (cyc_inc_i) cycle_q   <= cycle_q + 64'd1;
            if (ret_inc_i) instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

// File: rtl/ysyx_22050039_exu_seq.sv
// Multi-cycle instruction sequencer: owns PC/IR, runs FETCH->EXEC->(MEM)->WB,
// gates register writes and halts on ebreak or invalid opcode.
// Optional performance counters built when YSYX_22050039_PERF_EN is defined.
module ysyx_22050039_exu_seq
    import ysyx_22050039_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req,
    input  logic              ifu_ack,
    input  logic [31:0]       ifu_inst,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   pc,
    input  logic [2:0]        dec_func,
    input  logic              dec_mem,
    input  logic [XLEN-1:0]   exu_dnpc,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic              halt,
    output logic              trap,
    output logic [63:0]       cycle_cnt,
    output logic [63:0]       instret_cnt
);

    seq_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [31:0]       ir_q, ir_d;
    logic [2:0]        func_q, func_d;
    logic              ifu_req_q, mem_req_q, rf_we_q, halt_q, trap_q;

    // Next-state and datapath-register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        func_d  = func_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_ack) begin
                    ir_d    = ifu_inst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                func_d = dec_func;
                npc_d  = func_is_jump(dec_func) ? exu_dnpc : pc_q + XLEN'(4);
                if (dec_func == FUNC_EBREAK)   state_d = S_HALT;
                else if (dec_func == FUNC_INV) state_d = S_TRAP;
                else if (dec_mem)              state_d = S_MEM;
                else                           state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ack) state_d = S_WB;
            end
            S_WB: begin
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // State, datapath and Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            npc_q     <= '0;
            ir_q      <= '0;
            func_q    <= '0;
            ifu_req_q <= 1'b0;
            mem_req_q <= 1'b0;
            rf_we_q   <= 1'b0;
            halt_q    <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            func_q    <= func_d;
            ifu_req_q <= (state_d == S_FETCH);
            mem_req_q <= (state_d == S_MEM);
            rf_we_q   <= (state_d == S_WB) && func_writes_rf(func_d);
            halt_q    <= (state_d == S_HALT);
            trap_q    <= (state_d == S_TRAP);
        end
    end

    assign ifu_req = ifu_req_q;
    assign mem_req = mem_req_q;
    assign rf_we   = rf_we_q;
    assign halt    = halt_q;
    assign trap    = trap_q;
    assign inst    = ir_q;
    assign pc      = pc_q;

`ifdef YSYX_22050039_PERF_EN
    logic cyc_inc, ret_inc;

    // Count every cycle spent working on an instruction, and each retire.
    assign cyc_inc = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)   || (state_q == S_WB);
    assign ret_inc = (state_q == S_WB);

    ysyx_22050039_perf_cnt u_perf_cnt (
        .clk_i         (clk),
        .rst_ni        (rst),
        .cyc_inc_i     (cyc_inc),
        .ret_inc_i     (ret_inc),
        .cycle_cnt_o   (cycle_cnt),
        .instret_cnt_o (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050039_exu_seq.sv
// Self-checking bench for the multi-cycle sequencer: directed vector table,
// randomized instruction stream against an instruction-level model, and
// hand-written halt / trap / async-reset sequences.
module tb_ysyx_22050039_exu_seq;

`ifdef YSYX_22050039_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, ifu_ack;
    logic [31:0] ifu_inst, inst;
    logic [63:0] pc, exu_dnpc;
    logic [2:0]  dec_func;
    logic        dec_mem, mem_req, mem_ack, rf_we, halt, trap;
    logic [63:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    ysyx_22050039_exu_seq dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ifu_inst(ifu_inst),
        .inst(inst), .pc(pc),
        .dec_func(dec_func), .dec_mem(dec_mem), .exu_dnpc(exu_dnpc),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .rf_we(rf_we), .halt(halt), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Instruction-level model state.
    logic [63:0] mpc, mcyc, mret;

    typedef struct {
        logic [2:0]  f;
        logic        m;
        logic [63:0] dn;
        int          fd;
        int          md;
        logic [63:0] exp_pc;
        logic [63:0] exp_npc;
        logic        exp_we;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] perf_exp(input logic [63:0] v);
        return PERF ? v : 64'd0;
    endfunction

    task automatic chk_reset_values();
        chk("rst_reqs", {ifu_req, mem_req, rf_we, halt, trap}, 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", inst, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_instret", instret_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ifu_ack = 1'b0; ifu_inst = '0; mem_ack = 1'b0;
        dec_func = '0; dec_mem = 1'b0; exu_dnpc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values();
        rst = 1'b1;
        chk("idle_no_req", ifu_req, 0);
        step();
        mpc = RST_PC; mcyc = 0; mret = 0;
    endtask

    // Drives one instruction from its FETCH cycle to the next FETCH cycle.
    task automatic run_instr(input logic [2:0] f, input logic m, input logic [63:0] dn,
                             input int fd, input int md, input logic [63:0] exp_pc,
                             input logic [63:0] exp_npc, input logic exp_we, input int exp_cyc);
        logic [31:0] iw;
        iw = $urandom;
        chk("fetch_req", ifu_req, 1);
        chk("fetch_pc", pc, exp_pc);
        chk("fetch_quiet", {mem_req, rf_we, halt, trap}, 0);
        chk("cycle_cnt", cycle_cnt, perf_exp(mcyc));
        chk("instret_cnt", instret_cnt, perf_exp(mret));
        dec_func = 3'($urandom); dec_mem = 1'($urandom); mem_ack = 1'($urandom);
        for (int i = 0; i < fd; i++) begin
            ifu_ack = 1'b0; ifu_inst = $urandom;
            step();
            chk("fetch_hold", ifu_req, 1);
        end
        ifu_ack = 1'b1; ifu_inst = iw;
        step();
        // EXEC
        ifu_ack = 1'($urandom); ifu_inst = $urandom; mem_ack = 1'($urandom);
        chk("exec_reqs", {ifu_req, mem_req, rf_we}, 0);
        chk("exec_ir", inst, iw);
        chk("exec_pc", pc, exp_pc);
        dec_func = f; dec_mem = m; exu_dnpc = dn;
        step();
        dec_func = 3'($urandom); dec_mem = 1'($urandom); exu_dnpc = {$urandom, $urandom};
        if (f == 3'd6) begin
            chk("halt_set", {halt, trap, ifu_req, mem_req}, 4'b1000);
            mcyc = mcyc + 64'(fd + 2);
            return;
        end
        if (f == 3'd7) begin
            chk("trap_set", {halt, trap, ifu_req, mem_req}, 4'b0100);
            mcyc = mcyc + 64'(fd + 2);
            return;
        end
        if (m) begin
            chk("mem_req", mem_req, 1);
            for (int i = 0; i < md; i++) begin
                mem_ack = 1'b0;
                step();
                chk("mem_hold", mem_req, 1);
            end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'($urandom);
        end
        // WB
        chk("wb_rf_we", rf_we, exp_we);
        chk("wb_reqs", {ifu_req, mem_req}, 0);
        chk("wb_pc", pc, exp_pc);
        chk("wb_ir", inst, iw);
        step();
        mcyc = mcyc + 64'(exp_cyc);
        mret = mret + 64'd1;
        mpc  = exp_npc;
    endtask

    initial begin
        logic [63:0] hpc, hcyc;
        logic [2:0]  rf;
        logic        rm;
        logic [63:0] rdn, rnpc;
        int          rfd, rmd;

        // f, mem, dnpc, fetch delay, mem delay, pc, next pc, rf_we, cycles
        tbl[0] = '{3'd0, 1'b0, 64'h0,           0, 0, 64'h8000_0000, 64'h8000_0004, 1'b1, 3};
        tbl[1] = '{3'd0, 1'b0, 64'h0,           0, 0, 64'h8000_0004, 64'h8000_0008, 1'b1, 3};
        tbl[2] = '{3'd0, 1'b0, 64'h0,           2, 0, 64'h8000_0008, 64'h8000_000C, 1'b1, 5};
        tbl[3] = '{3'd5, 1'b0, 64'h8000_0100,   0, 0, 64'h8000_000C, 64'h8000_0100, 1'b1, 3};
        tbl[4] = '{3'd4, 1'b1, 64'h0,           0, 3, 64'h8000_0100, 64'h8000_0104, 1'b0, 7};
        tbl[5] = '{3'd1, 1'b0, 64'h8000_0200,   1, 0, 64'h8000_0104, 64'h8000_0200, 1'b1, 4};
        tbl[6] = '{3'd2, 1'b0, 64'h1234_5678,   0, 0, 64'h8000_0200, 64'h8000_0204, 1'b1, 3};
        tbl[7] = '{3'd3, 1'b1, 64'h0,           0, 0, 64'h8000_0204, 64'h8000_0208, 1'b1, 4};

        do_reset();
        for (int i = 0; i < 8; i++)
            run_instr(tbl[i].f, tbl[i].m, tbl[i].dn, tbl[i].fd, tbl[i].md,
                      tbl[i].exp_pc, tbl[i].exp_npc, tbl[i].exp_we, tbl[i].exp_cyc);

        // Random stream against the instruction-level model.
        for (int i = 0; i < 40; i++) begin
            rf   = 3'($urandom_range(0, 5));
            rm   = 1'($urandom);
            rdn  = {$urandom, $urandom};
            rfd  = int'($urandom_range(0, 3));
            rmd  = int'($urandom_range(0, 3));
            rnpc = (rf == 3'd1 || rf == 3'd5) ? rdn : mpc + 64'd4;
            run_instr(rf, rm, rdn, rfd, rmd, mpc, rnpc,
                      (rf != 3'd4), rfd + 3 + (rm ? rmd + 1 : 0));
        end

        // ebreak: sticky halt, no requests, pc and counters frozen.
        hpc = mpc;
        run_instr(3'd6, 1'b0, 64'h0, 0, 0, mpc, 64'h0, 1'b0, 0);
        hcyc = mcyc;
        for (int i = 0; i < 20; i++) begin
            ifu_ack = 1'($urandom); mem_ack = 1'($urandom);
            dec_func = 3'($urandom); dec_mem = 1'($urandom);
            step();
            chk("halt_hold", {halt, trap, ifu_req, mem_req, rf_we}, 5'b10000);
            chk("halt_pc", pc, hpc);
            chk("halt_cycle", cycle_cnt, perf_exp(hcyc));
        end

        // Invalid opcode at 8000_0008: sticky trap, pc holds the faulting address.
        do_reset();
        run_instr(3'd0, 1'b0, 64'h0, 0, 0, 64'h8000_0000, 64'h8000_0004, 1'b1, 3);
        run_instr(3'd0, 1'b0, 64'h0, 0, 0, 64'h8000_0004, 64'h8000_0008, 1'b1, 3);
        run_instr(3'd7, 1'b1, 64'h0, 0, 0, 64'h8000_0008, 64'h0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            ifu_ack = 1'($urandom); mem_ack = 1'($urandom);
            step();
            chk("trap_hold", {halt, trap, ifu_req, mem_req, rf_we}, 5'b01000);
            chk("trap_pc", pc, 64'h8000_0008);
        end
        chk("trap_instret", instret_cnt, perf_exp(64'd2));

        // Asynchronous reset in the middle of a fetch handshake.
        do_reset();
        run_instr(3'd0, 1'b0, 64'h0, 1, 0, 64'h8000_0000, 64'h8000_0004, 1'b1, 4);
        ifu_ack = 1'b0;
        step();
        chk("pre_rst_req", ifu_req, 1);
        chk("pre_rst_pc", pc, 64'h8000_0004);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req_drop", ifu_req, 0);
        chk_reset_values();
        step();
        rst = 1'b1;
        chk_reset_values();
        step();
        chk("post_rst_req", ifu_req, 1);
        chk("post_rst_pc", pc, RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
